// File: rtl/carry_chain_sched.sv
// carry_chain_sched
//   Round-robin scheduler that time-shares one external SEG_W-bit carry-chain
//   adder among NREQ requesters. Each accepted add/subtract of OP_W = SEG_W*NSEG
//   bits is rippled through the adder one segment per cycle, LSB segment first.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready     per-requester handshake (ready is one-hot or zero)
//   req_sub                 per-requester op select: 1 = A-B, 0 = A+B
//   req_a/req_b             packed operands, requester i at [i*OP_W +: OP_W]
//   rsp_valid/rsp_ready     result handshake
//   rsp_id/rsp_sum/rsp_cout result owner, result value, carry out of MSB
//   seg_a/seg_b/seg_ci      slice presented to the shared adder (seg_b pre-inverted)
//   seg_sum/seg_co          combinational adder result
//   rsp_ovf                 signed overflow, only with CARRY_CHAIN_SCHED_OVF_EN
//
// Build option: define CARRY_CHAIN_SCHED_OVF_EN to add rsp_ovf.
module carry_chain_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned SEG_W = 8,
  parameter int unsigned NSEG  = 4,
  localparam int unsigned OP_W = SEG_W * NSEG,
  localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_sub,
  input  logic [NREQ*OP_W-1:0] req_a,
  input  logic [NREQ*OP_W-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [OP_W-1:0]      rsp_sum,
  output logic                 rsp_cout,
  output logic [SEG_W-1:0]     seg_a,
  output logic [SEG_W-1:0]     seg_b,
  output logic                 seg_ci,
  input  logic [SEG_W-1:0]     seg_sum,
  input  logic                 seg_co
`ifdef CARRY_CHAIN_SCHED_OVF_EN
  , output logic               rsp_ovf
`endif
);

  localparam int unsigned KW = (NSEG > 1) ? $clog2(NSEG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_e;

  state_e                      state_q, state_d;
  logic [IDW-1:0]              ptr_q;
  logic [IDW-1:0]              id_q;
  logic [KW-1:0]               k_q;
  logic                        carry_q;
  logic [NSEG-1:0][SEG_W-1:0]  a_q, b_q, sum_q;
  logic                        cout_q;
`ifdef CARRY_CHAIN_SCHED_OVF_EN
  logic                        ovf_q;
`endif

  logic                        gnt_vld;
  logic [IDW-1:0]              gnt_idx;
  logic [OP_W-1:0]             a_sel, b_sel;
  logic                        sub_sel;
  logic                        accept;
  logic                        last_seg;

  // Round-robin search: offset i from ptr, first valid requester wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!gnt_vld && req_valid[j] && ((32'(ptr_q) + i) % NREQ) == j) begin
          gnt_vld = 1'b1;
          gnt_idx = IDW'(j);
        end
      end
    end
  end

  // Operand mux for the winner; B is inverted here so the adder only adds.
  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    sub_sel = 1'b0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (gnt_idx == IDW'(j)) begin
        a_sel   = req_a[j*OP_W +: OP_W];
        b_sel   = req_sub[j] ? ~req_b[j*OP_W +: OP_W] : req_b[j*OP_W +: OP_W];
        sub_sel = req_sub[j];
      end
    end
  end

  assign accept   = (state_q == IDLE) && gnt_vld;
  assign last_seg = (k_q == KW'(NSEG - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt_vld)   state_d = RUN;
      RUN:     if (last_seg)  state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = '0;
    seg_a     = '0;
    seg_b     = '0;
    seg_ci    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Gated by rst_n so nothing is offered while reset is held.
        for (int unsigned j = 0; j < NREQ; j++)
          req_ready[j] = rst_n && gnt_vld && (gnt_idx == IDW'(j));
      end
      RUN: begin
        seg_a  = a_q[k_q];
        seg_b  = b_q[k_q];
        seg_ci = carry_q;
      end
      default: ;
    endcase
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
`ifdef CARRY_CHAIN_SCHED_OVF_EN
  assign rsp_ovf   = ovf_q;
`endif

  // Datapath and arbitration pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      id_q    <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef CARRY_CHAIN_SCHED_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        a_q     <= a_sel;
        b_q     <= b_sel;
        id_q    <= gnt_idx;
        k_q     <= '0;
        carry_q <= sub_sel;
        ptr_q   <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
      end else if (state_q == RUN) begin
        sum_q[k_q] <= seg_sum;
        carry_q    <= seg_co;
        k_q        <= k_q + KW'(1);
        if (last_seg) begin
          cout_q <= seg_co;
`ifdef CARRY_CHAIN_SCHED_OVF_EN
          // Carry into the MSB is recovered from the MSB sum bit and its inputs.
          ovf_q  <= seg_a[SEG_W-1] ^ seg_b[SEG_W-1] ^ seg_sum[SEG_W-1] ^ seg_co;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_carry_chain_sched.sv
module tb_carry_chain_sched;

  localparam int NREQ  = 4;
  localparam int SEG_W = 8;
  localparam int NSEG  = 4;
  localparam int OP_W  = 32;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      req_sub;
  logic [NREQ*OP_W-1:0] req_a;
  logic [NREQ*OP_W-1:0] req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [1:0]           rsp_id;
  logic [OP_W-1:0]      rsp_sum;
  logic                 rsp_cout;
  logic [SEG_W-1:0]     seg_a;
  logic [SEG_W-1:0]     seg_b;
  logic                 seg_ci;
  logic [SEG_W-1:0]     seg_sum;
  logic                 seg_co;
`ifdef CARRY_CHAIN_SCHED_OVF_EN
  logic                 rsp_ovf;
`endif

  always #5 clk = ~clk;

  // Shared carry-chain adder
  assign {seg_co, seg_sum} = {1'b0, seg_a} + {1'b0, seg_b} + {8'b0, seg_ci};

  carry_chain_sched #(.NREQ(NREQ), .SEG_W(SEG_W), .NSEG(NSEG)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .seg_a(seg_a), .seg_b(seg_b), .seg_ci(seg_ci),
    .seg_sum(seg_sum), .seg_co(seg_co)
`ifdef CARRY_CHAIN_SCHED_OVF_EN
    , .rsp_ovf(rsp_ovf)
`endif
  );

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct packed {
    logic [1:0]  id;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  exp_t exp_q[$];
  int   vectors      = 0;
  int   miscompares  = 0;
  int   cyc          = 0;
  int   last_rsp_cyc = -1;
  bit   chk_interval = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [1:0] id, input logic [31:0] sum,
                              input logic cout, input logic ovf);
    exp_t e;
    e.id = id; e.sum = sum; e.cout = cout; e.ovf = ovf;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    vectors++;
    miscompares++;
    $display("FAIL %s: actual %s required none", name, what);
  endtask

  task automatic drive(input int i, input logic sub, input logic [31:0] a, input logic [31:0] b);
    req_valid[i]             = 1'b1;
    req_sub[i]               = sub;
    req_a[i*OP_W +: OP_W]    = a;
    req_b[i*OP_W +: OP_W]    = b;
  endtask

  // One clock; requesters drop valid after the edge that accepted them.
  task automatic cycle();
    logic [NREQ-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc;
  endtask

  task automatic wait_accept(input string name);
    int n = 0;
    while (req_valid != '0 && n < 100) begin
      cycle();
      n++;
    end
    if (req_valid != '0) begin
      fail_now(name, "accept timeout");
      req_valid = '0;
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      fail_now(name, "response timeout");
      exp_q.delete();
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_rsp", "response");
        end else begin
          e = exp_q.pop_front();
          check("rsp_id",   64'(rsp_id),   64'(e.id));
          check("rsp_sum",  64'(rsp_sum),  64'(e.sum));
          check("rsp_cout", 64'(rsp_cout), 64'(e.cout));
`ifdef CARRY_CHAIN_SCHED_OVF_EN
          check("rsp_ovf",  64'(rsp_ovf),  64'(e.ovf));
`endif
        end
        if (chk_interval) begin
          if (last_rsp_cyc >= 0)
            check("rsp_interval", 64'(cyc - last_rsp_cyc), 64'd6);
          last_rsp_cyc = cyc;
        end
      end
    end
  endtask

  // Directed vectors: id, sub, A, B, expected sum, cout, ovf
  vec_t vecs[6] = '{
    '{2'd0, 1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0},
    '{2'd1, 1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0},
    '{2'd2, 1'b1, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b1, 1'b0},
    '{2'd3, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0},
    '{2'd0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1},
    '{2'd1, 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1}
  };

  initial begin
    #200000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int  n;
    bit  again;

    rst_n     = 1'b0;
    req_valid = '0;
    req_sub   = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    fork
      monitor();
    join_none

    // Reset state, with a request pending to show ready stays low.
    req_valid[0] = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp",       64'({rsp_id, rsp_cout, rsp_sum}), 64'd0);
    check("rst_seg",       64'({seg_a, seg_b, seg_ci}), 64'd0);
    req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Carry ripples from segment 0 into segment 1.
    drive(0, vecs[0].sub, vecs[0].a, vecs[0].b);
    exp_q.push_back(mk(vecs[0].id, vecs[0].sum, vecs[0].cout, vecs[0].ovf));
    wait_accept("acc_add");
    check("run0_seg", 64'({seg_a, seg_b, seg_ci}), 64'({8'hFF, 8'h01, 1'b0}));
    @(posedge clk);
    #1;
    check("run1_seg", 64'({seg_a, seg_b, seg_ci}), 64'({8'h00, 8'h00, 1'b1}));
    wait_drain("drain_add");

    // Subtract: inverted B and carry-in of 1 in the first RUN cycle.
    drive(1, vecs[1].sub, vecs[1].a, vecs[1].b);
    exp_q.push_back(mk(vecs[1].id, vecs[1].sum, vecs[1].cout, vecs[1].ovf));
    wait_accept("acc_sub");
    check("sub_run0_seg", 64'({seg_a, seg_b, seg_ci}), 64'({8'h00, 8'hFE, 1'b1}));
    wait_drain("drain_sub");

    for (int i = 2; i < 6; i++) begin
      drive(int'(vecs[i].id), vecs[i].sub, vecs[i].a, vecs[i].b);
      exp_q.push_back(mk(vecs[i].id, vecs[i].sum, vecs[i].cout, vecs[i].ovf));
      wait_accept("acc_vec");
      wait_drain("drain_vec");
    end

    // All four valid from reset: grants 0,1,2,3,0 at 6-cycle spacing.
    @(posedge clk);
    #1 rst_n = 1'b0;
    drive(0, 1'b0, 32'h0000_0001, 32'h0000_0002);
    drive(1, 1'b1, 32'h0000_0010, 32'h0000_0004);
    drive(2, 1'b0, 32'h0100_0000, 32'h0100_0000);
    drive(3, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    exp_q.push_back(mk(2'd0, 32'h0000_0003, 1'b0, 1'b0));
    exp_q.push_back(mk(2'd1, 32'h0000_000C, 1'b1, 1'b0));
    exp_q.push_back(mk(2'd2, 32'h0200_0000, 1'b0, 1'b0));
    exp_q.push_back(mk(2'd3, 32'h0000_0000, 1'b1, 1'b0));
    chk_interval = 1'b1;
    last_rsp_cyc = -1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    again = 1'b0;
    while ((req_valid != '0 || !again) && n < 200) begin
      cycle();
      n++;
      if (!again && !req_valid[0]) begin
        drive(0, 1'b0, 32'h1234_5678, 32'h1111_1111);
        exp_q.push_back(mk(2'd0, 32'h2345_6789, 1'b0, 1'b0));
        again = 1'b1;
      end
    end
    if (req_valid != '0) begin
      fail_now("acc_rr", "accept timeout");
      req_valid = '0;
    end
    wait_drain("drain_rr");
    chk_interval = 1'b0;

    // Response stall for 3 cycles with another requester waiting.
    rsp_ready = 1'b0;
    drive(3, 1'b0, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
    exp_q.push_back(mk(2'd3, 32'hFFFF_FFFF, 1'b0, 1'b0));
    wait_accept("acc_stall");
    drive(1, 1'b0, 32'h0000_0010, 32'h0000_0020);
    exp_q.push_back(mk(2'd1, 32'h0000_0030, 1'b0, 1'b0));
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) fail_now("stall_wait", "no rsp_valid");
    for (int c = 0; c < 3; c++) begin
      check("stall_rsp",   64'({rsp_valid, rsp_id, rsp_cout, rsp_sum}),
                           64'({1'b1, 2'd3, 1'b0, 32'hFFFF_FFFF}));
      check("stall_ready", 64'(req_ready), 64'd0);
      check("stall_seg",   64'({seg_a, seg_b, seg_ci}), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("resume_ready", 64'(req_ready), 64'b0010);
    wait_accept("acc_resume");
    wait_drain("drain_stall");

    // Reset during RUN k=2: in-flight op dropped, lowest valid index wins after.
    drive(0, 1'b0, 32'h00AA_0000, 32'h0011_0000);
    wait_accept("acc_drop");
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("k2_seg", 64'({seg_a, seg_b, seg_ci}), 64'({8'hAA, 8'h11, 1'b0}));
    drive(3, 1'b1, 32'h0000_0300, 32'h0000_0300);
    drive(2, 1'b0, 32'h0000_0100, 32'h0000_0200);
    rst_n = 1'b0;
    #1;
    check("midrst_seg",   64'({seg_a, seg_b, seg_ci}), 64'd0);
    check("midrst_ready", 64'(req_ready), 64'd0);
    check("midrst_rsp",   64'({rsp_valid, rsp_id, rsp_cout, rsp_sum}), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.push_back(mk(2'd2, 32'h0000_0300, 1'b0, 1'b0));
    exp_q.push_back(mk(2'd3, 32'h0000_0000, 1'b1, 1'b0));
    wait_accept("acc_postrst");
    wait_drain("drain_postrst");

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/carry_chain_sched.md
CARRY_CHAIN_SCHED -- requirements
Module: carry_chain_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters, range 2..8.
REQ-002 SHALL have parameter SEG_W, default 8: width of the shared adder segment.
REQ-003 SHALL have parameter NSEG, default 4: segments per operation; operand width OP_W = SEG_W*NSEG.
REQ-004 One clock; reset is asynchronous and active-low. Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept, one-hot or zero.
- req_sub  in  NREQ  per-requester op: 1 = A-B, 0 = A+B.
- req_a  in  NREQ*OP_W  operand A, requester i at bits [i*OP_W +: OP_W].
- req_b  in  NREQ*OP_W  operand B, same packing.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumer ready.
- rsp_id  out  clog2(NREQ)  index of the requester the result belongs to.
- rsp_sum  out  OP_W  result.
- rsp_cout  out  1  carry out of the MSB.
- seg_a  out  SEG_W  A slice to the shared carry-chain adder.
- seg_b  out  SEG_W  B slice to the adder, already inverted for subtract.
- seg_ci  out  1  carry-in to the adder.
- seg_sum  in  SEG_W  adder sum, combinational from seg_a/seg_b/seg_ci.
- seg_co  in  1  adder carry-out, combinational.

Function
REQ-005 FSM states SHALL be IDLE, RUN, RESP.
REQ-006 In IDLE, arbitration SHALL be round-robin: the search starts at ptr = (last granted + 1) mod NREQ, and the first asserted req_valid wins.
REQ-007 req_ready[g] SHALL be asserted combinationally only in IDLE, only for the winner g; all bits are 0 in RUN and RESP.
REQ-008 On the accept edge (req_valid[g] & req_ready[g]), the block SHALL latch A, B (inverted if req_sub[g]), sub and id = g; set seg index k = 0 and carry = req_sub[g]; then go to RUN.
REQ-009 In RUN, seg_a/seg_b SHALL present slice k of the latched operands, and seg_ci SHALL equal the stored carry.
REQ-010 On each RUN edge, the block SHALL store seg_sum into result slice k, store seg_co as the carry, and increment k.
REQ-011 After slice NSEG-1, the block SHALL go to RESP; rsp_cout = final seg_co.
REQ-012 In IDLE and RESP, seg_a, seg_b and seg_ci SHALL be 0.
REQ-013 rsp_valid SHALL be high only in RESP. rsp_sum, rsp_id and rsp_cout SHALL be registered and stable while rsp_valid=1 & rsp_ready=0.
REQ-014 Latency: accept at edge 0, segments at edges 1..NSEG, rsp_valid high from edge NSEG onward; rsp_ready=1 at edge NSEG+1 returns the block to IDLE.
REQ-015 There SHALL be one IDLE bubble cycle between results; the minimum issue interval is NSEG+2 cycles.
REQ-016 When multiple requesters are valid simultaneously, exactly one SHALL be granted; the rest wait and no request is lost.
REQ-017 A requester SHALL hold req_valid and operands stable until accepted; the block SHALL NOT sample operands outside the accept edge.
REQ-018 When no req_valid is asserted, the block SHALL stay in IDLE and ptr SHALL stay unchanged.

Reset
REQ-019 When rst_n=0, the block SHALL asynchronously force IDLE, ptr=0, k=0, carry=0; rsp_valid, rsp_sum, rsp_id, rsp_cout, seg_* and req_ready SHALL all be 0.
REQ-020 Reset mid-RUN or mid-RESP SHALL drop the in-flight operation with no response; the first grant after release goes to the lowest-index valid requester.

Configuration
REQ-021 With macro CARRY_CHAIN_SCHED_OVF_EN defined, the block SHALL add output rsp_ovf (1 bit) = carry into MSB XOR rsp_cout, i.e. signed overflow; it is registered with the final segment, held in RESP, and reset to 0.
REQ-022 Without CARRY_CHAIN_SCHED_OVF_EN, rsp_ovf SHALL be absent and no overflow logic is built.

Verification (NREQ=4, SEG_W=8, NSEG=4)
REQ-023 req0 add, A=0x000000FF, B=0x00000001 -> after 4 RUN cycles: rsp_sum=0x00000100, rsp_cout=0, rsp_id=0; the carry crosses segment 0->1.
REQ-024 req1 sub, A=0x00000000, B=0x00000001 -> seg_ci=1 in the first RUN cycle; rsp_sum=0xFFFFFFFF, rsp_cout=0, rsp_id=1.
REQ-025 All four requesters valid from reset, rsp_ready=1 -> grant order 0,1,2,3,0; each result appears 6 cycles after the previous one.
REQ-026 rsp_ready held 0 for 3 cycles in RESP -> rsp_* stable, req_ready=0000, seg_*=0; grant resumes the cycle after the handshake.
REQ-027 rst_n pulsed low during RUN k=2 -> all outputs 0 immediately, no response is issued; after release with req2 and req3 valid, req2 is granted first.
REQ-028 With CARRY_CHAIN_SCHED_OVF_EN: add A=0x7FFFFFFF, B=0x00000001 -> rsp_sum=0x80000000, rsp_ovf=1, rsp_cout=0.
